// File: rtl/alu_flag_branch_unit.sv
// Status flags, branch condition evaluation, taken-branch redirect
// handshake and saturating branch statistics counters.
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   alu_z/alu_n/alu_v   : ALU flags, latched into flags_q on flag_we
//   br_valid/br_ready   : branch request handshake
//   br_cond/br_target   : condition code and target PC of request
//   redirect_valid/
//   redirect_ready/
//   redirect_pc         : taken-branch redirect to the PC stage
//   flags_q             : stored status {Z,N,V}
//   cnt_clr             : clear both statistics counters
//   br_cnt/taken_cnt    : accepted / accepted-and-taken counts
module alu_flag_branch_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alu_z,
  input  logic             alu_n,
  input  logic             alu_v,
  input  logic             flag_we,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [2:0]       br_cond,
  input  logic [31:0]      br_target,
  output logic             redirect_valid,
  input  logic             redirect_ready,
  output logic [31:0]      redirect_pc,
  output logic [2:0]       flags_q,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q;
  state_t           state_d;
  logic [2:0]       flags_d;
  logic [31:0]      redirect_pc_q;
  logic [31:0]      redirect_pc_d;
  logic [CNT_W-1:0] br_cnt_q;
  logic [CNT_W-1:0] br_cnt_d;
  logic [CNT_W-1:0] taken_cnt_q;
  logic [CNT_W-1:0] taken_cnt_d;

  logic [2:0]       eval_flags;
  logic             flag_z;
  logic             flag_n;
  logic             flag_v;
  logic             cond_hit;
  logic             accept;
  logic             taken;

  assign br_ready       = (state_q == IDLE);
  assign redirect_valid = (state_q == HOLD);
  assign redirect_pc    = redirect_pc_q;
  assign br_cnt         = br_cnt_q;
  assign taken_cnt      = taken_cnt_q;

  assign accept = br_valid && br_ready;
  assign taken  = accept && cond_hit;

  // Flags being written this cycle are visible to a
  // same-cycle branch, so the compare sees fresh results.
  always_comb begin
    eval_flags = flags_q;
    if (flag_we) begin
      eval_flags = {alu_z, alu_n, alu_v};
    end
  end

  assign flag_z = eval_flags[2];
  assign flag_n = eval_flags[1];
  assign flag_v = eval_flags[0];

  always_comb begin
    cond_hit = 1'b0;
    unique case (br_cond)
      3'b000: cond_hit = flag_z;
      3'b001: cond_hit = ~flag_z;
      3'b010: cond_hit = flag_n ^ flag_v;
      3'b011: cond_hit = ~(flag_n ^ flag_v);
      3'b100: cond_hit = flag_v;
      3'b101: cond_hit = ~flag_v;
      3'b110: cond_hit = 1'b1;
      3'b111: cond_hit = 1'b0;
    endcase
  end

  always_comb begin
    flags_d = flags_q;
    if (flag_we) begin
      flags_d = {alu_z, alu_n, alu_v};
    end
  end

  // Redirect target is captured only on a taken accept and
  // otherwise held, so it stays stable while HOLD waits.
  always_comb begin
    state_d       = state_q;
    redirect_pc_d = redirect_pc_q;
    unique case (state_q)
      IDLE: begin
        if (taken) begin
          state_d       = HOLD;
          redirect_pc_d = br_target;
        end
      end
      HOLD: begin
        if (redirect_ready) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // Counters saturate at all-ones; clear wins over a
  // same-cycle increment.
  always_comb begin
    br_cnt_d    = br_cnt_q;
    taken_cnt_d = taken_cnt_q;
    if (cnt_clr) begin
      br_cnt_d    = '0;
      taken_cnt_d = '0;
    end else begin
      if (accept && (br_cnt_q != CNT_MAX)) begin
        br_cnt_d = br_cnt_q + CNT_ONE;
      end
      if (taken && (taken_cnt_q != CNT_MAX)) begin
        taken_cnt_d = taken_cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      flags_q       <= 3'b000;
      redirect_pc_q <= 32'h0;
      br_cnt_q      <= '0;
      taken_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      flags_q       <= flags_d;
      redirect_pc_q <= redirect_pc_d;
      br_cnt_q      <= br_cnt_d;
      taken_cnt_q   <= taken_cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_flag_branch_unit.sv
// Randomized and directed bench for alu_flag_branch_unit with a
// behavioural reference model compared on every cycle.
module tb_alu_flag_branch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_z, alu_n, alu_v;
  logic        flag_we;
  logic        br_valid;
  logic        br_ready;
  logic [2:0]  br_cond;
  logic [31:0] br_target;
  logic        redirect_valid;
  logic        redirect_ready;
  logic [31:0] redirect_pc;
  logic [2:0]  flags_q;
  logic        cnt_clr;
  logic [15:0] br_cnt;
  logic [15:0] taken_cnt;

  int checks = 0;
  int errors = 0;
  bit check_en = 0;

  // reference model state
  bit          m_hold = 0;
  bit [2:0]    m_flags = 0;
  bit [31:0]   m_pc = 0;
  int          m_br = 0;
  int          m_taken = 0;

  alu_flag_branch_unit #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .alu_z(alu_z), .alu_n(alu_n), .alu_v(alu_v),
    .flag_we(flag_we),
    .br_valid(br_valid), .br_ready(br_ready),
    .br_cond(br_cond), .br_target(br_target),
    .redirect_valid(redirect_valid),
    .redirect_ready(redirect_ready),
    .redirect_pc(redirect_pc),
    .flags_q(flags_q),
    .cnt_clr(cnt_clr),
    .br_cnt(br_cnt), .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit cond_true(bit [2:0] c, bit [2:0] f);
    bit z, n, v;
    z = f[2]; n = f[1]; v = f[0];
    case (c)
      3'd0: return z;
      3'd1: return !z;
      3'd2: return n != v;
      3'd3: return n == v;
      3'd4: return v;
      3'd5: return !v;
      3'd6: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    bit [2:0] eff;
    bit acc, tk;
    if (reset) begin
      m_hold = 0; m_flags = 0; m_pc = 0;
      m_br = 0; m_taken = 0;
    end else begin
      eff = flag_we ? {alu_z, alu_n, alu_v} : m_flags;
      acc = br_valid && !m_hold;
      tk  = acc && cond_true(br_cond, eff);
      if (flag_we) m_flags = {alu_z, alu_n, alu_v};
      if (m_hold) begin
        if (redirect_ready) m_hold = 0;
      end else if (tk) begin
        m_hold = 1;
        m_pc = br_target;
      end
      if (cnt_clr) begin
        m_br = 0; m_taken = 0;
      end else begin
        if (acc && m_br < 65535) m_br++;
        if (tk && m_taken < 65535) m_taken++;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("m_br_ready", br_ready, !m_hold);
      chk("m_redirect_valid", redirect_valid, m_hold);
      chk("m_redirect_pc", redirect_pc, m_pc);
      chk("m_flags", flags_q, m_flags);
      chk("m_br_cnt", br_cnt, m_br);
      chk("m_taken_cnt", taken_cnt, m_taken);
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_flags(bit z, bit n, bit v);
    flag_we = 1; alu_z = z; alu_n = n; alu_v = v;
    tick();
    flag_we = 0;
  endtask

  task automatic do_br(string name, bit [2:0] c,
                       bit [31:0] tgt, bit exp_tk);
    br_valid = 1; br_cond = c; br_target = tgt;
    tick();
    br_valid = 0;
    chk(name, redirect_valid, exp_tk);
    if (exp_tk) chk({name, "_pc"}, redirect_pc, tgt);
    if (exp_tk || redirect_valid) begin
      redirect_ready = 1;
      tick();
      redirect_ready = 0;
    end
  endtask

  initial begin
    int save_br;
    reset = 1; flag_we = 0; alu_z = 0; alu_n = 0; alu_v = 0;
    br_valid = 0; br_cond = 0; br_target = 0;
    redirect_ready = 0; cnt_clr = 0;
    tick(); tick();
    reset = 0;
    chk("rst_br_ready", br_ready, 1);
    chk("rst_rv", redirect_valid, 0);
    chk("rst_pc", redirect_pc, 0);
    chk("rst_flags", flags_q, 0);
    chk("rst_br_cnt", br_cnt, 0);
    chk("rst_taken_cnt", taken_cnt, 0);
    check_en = 1;

    // EQ taken, latency one
    set_flags(1, 0, 0);
    br_valid = 1; br_cond = 3'd0; br_target = 32'h40;
    tick();
    br_valid = 0;
    chk("eq_rv", redirect_valid, 1);
    chk("eq_pc", redirect_pc, 32'h40);
    chk("eq_br_cnt", br_cnt, 1);
    chk("eq_taken_cnt", taken_cnt, 1);
    redirect_ready = 1; tick(); redirect_ready = 0;
    chk("eq_release", br_ready, 1);

    // bypass: same-cycle z=0 overrides stored Z=1
    flag_we = 1; alu_z = 0; alu_n = 0; alu_v = 0;
    br_valid = 1; br_cond = 3'd0; br_target = 32'h80;
    tick();
    flag_we = 0; br_valid = 0;
    chk("byp_rv", redirect_valid, 0);
    chk("byp_br_cnt", br_cnt, 2);
    chk("byp_taken_cnt", taken_cnt, 1);

    set_flags(0, 1, 1);
    do_br("lt_nv11", 3'd2, 32'h100, 0);
    do_br("ge_nv11", 3'd3, 32'h104, 1);
    set_flags(0, 1, 0);
    do_br("lt_nv10", 3'd2, 32'h108, 1);
    do_br("ge_nv10", 3'd3, 32'h10c, 0);
    set_flags(0, 0, 1);
    do_br("vs_v1", 3'd4, 32'h110, 1);
    do_br("vc_v1", 3'd5, 32'h114, 0);
    do_br("ne_z0", 3'd1, 32'h118, 1);
    do_br("always", 3'd6, 32'h11c, 1);
    do_br("never", 3'd7, 32'h120, 0);

    // HOLD with redirect_ready low and a waiting request
    br_valid = 1; br_cond = 3'd6; br_target = 32'h100;
    tick();
    save_br = m_br;
    br_target = 32'h200;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_pc", redirect_pc, 32'h100);
      chk("hold_ready", br_ready, 0);
      chk("hold_cnt", br_cnt, save_br);
    end
    redirect_ready = 1; tick(); redirect_ready = 0;
    chk("hold_exit", redirect_valid, 0);
    tick();
    br_valid = 0;
    chk("second_rv", redirect_valid, 1);
    chk("second_pc", redirect_pc, 32'h200);
    chk("second_cnt", br_cnt, save_br + 1);
    redirect_ready = 1; tick(); redirect_ready = 0;

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      reset    = ($urandom_range(0, 99) == 0);
      cnt_clr  = ($urandom_range(0, 31) == 0);
      flag_we  = $urandom_range(0, 1);
      alu_z    = $urandom_range(0, 1);
      alu_n    = $urandom_range(0, 1);
      alu_v    = $urandom_range(0, 1);
      br_valid = $urandom_range(0, 1);
      br_cond  = 3'($urandom_range(0, 7));
      br_target = $urandom;
      redirect_ready = $urandom_range(0, 1);
      tick();
    end
    reset = 0; cnt_clr = 0; flag_we = 0; br_valid = 0;
    redirect_ready = 1; tick(); redirect_ready = 0;

    // saturation
    cnt_clr = 1; tick(); cnt_clr = 0;
    br_valid = 1; br_cond = 3'd7;
    repeat (65534) tick();
    br_valid = 0;
    chk("sat_fffe", br_cnt, 32'hFFFE);
    do_br("sat_a1", 3'd6, 32'h300, 1);
    do_br("sat_a2", 3'd6, 32'h304, 1);
    do_br("sat_a3", 3'd6, 32'h308, 1);
    chk("sat_ffff", br_cnt, 32'hFFFF);
    chk("sat_taken", taken_cnt, 3);
    cnt_clr = 1; br_valid = 1; br_cond = 3'd6;
    br_target = 32'h30c;
    tick();
    cnt_clr = 0; br_valid = 0;
    chk("clr_br_cnt", br_cnt, 0);
    chk("clr_taken_cnt", taken_cnt, 0);
    redirect_ready = 1; tick(); redirect_ready = 0;

    // reset while HOLD drops redirect
    do_br("pre_rst", 3'd6, 32'h1234, 1);
    br_valid = 1; br_cond = 3'd6; br_target = 32'h1234;
    tick();
    br_valid = 0;
    chk("hold_rst_pc", redirect_pc, 32'h1234);
    reset = 1; flag_we = 1; alu_z = 1; alu_n = 1; alu_v = 1;
    cnt_clr = 1;
    tick();
    reset = 0; flag_we = 0; cnt_clr = 0;
    chk("hrst_rv", redirect_valid, 0);
    chk("hrst_pc", redirect_pc, 0);
    chk("hrst_flags", flags_q, 0);
    chk("hrst_ready", br_ready, 1);
    tick(); tick();

    check_en = 0;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_flag_branch_unit.md
ALU_FLAG_BRANCH_UNIT -- requirements
Module: alu_flag_branch_unit

Interface
REQ-001 Parameter: CNT_W, default 16, width of branch statistics counters.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 alu_z  input  1  ALU zero flag (result == 0).
REQ-005 alu_n  input  1  ALU negative flag (result bit 31).
REQ-006 alu_v  input  1  ALU overflow flag (ADD/SUB only, else 0).
REQ-007 flag_we  input  1  latch alu_z/alu_n/alu_v into status register this cycle.
REQ-008 br_valid  input  1  branch request present.
REQ-009 br_ready  output  1  unit can accept a branch request.
REQ-010 br_cond  input  3  condition code of request.
REQ-011 br_target  input  32  target PC of request.
REQ-012 redirect_valid  output  1  taken-branch redirect pending.
REQ-013 redirect_ready  input  1  PC stage consumes redirect.
REQ-014 redirect_pc  output  32  target PC of pending redirect.
REQ-015 flags_q  output  3  stored status {Z,N,V}.
REQ-016 cnt_clr  input  1  synchronous clear of both counters.
REQ-017 br_cnt  output  CNT_W  branches accepted.
REQ-018 taken_cnt  output  CNT_W  branches accepted and taken.

Function
REQ-019 Status register SHALL load {alu_z,alu_n,alu_v} on flag_we, else hold; flag_we honoured in every state.
REQ-020 Accept SHALL occur when br_valid && br_ready.
REQ-021 Flags evaluated at accept SHALL be the incoming ALU flags if flag_we is high that cycle (bypass), else flags_q.
REQ-022 Conditions: 000 EQ=Z; 001 NE=~Z; 010 LT=N^V; 011 GE=~(N^V); 100 VS=V; 101 VC=~V; 110 ALWAYS=1; 111 NEVER=0.
REQ-025 FSM states IDLE and HOLD; br_ready = (state==IDLE), combinational from state only.
REQ-026 IDLE: accepted taken branch -> HOLD next cycle, redirect_valid=1, redirect_pc=br_target captured at accept (latency 1 cycle).
REQ-027 IDLE: accepted not-taken branch -> stay IDLE, no redirect.
REQ-028 HOLD: redirect_valid and redirect_pc SHALL stay stable until redirect_ready sampled high; that cycle -> IDLE, redirect_valid=0 next cycle.
REQ-029 HOLD: br_valid SHALL be ignored (no accept, no counting); requester must hold request.
REQ-030 br_cnt increments by 1 per accept; taken_cnt increments by 1 per taken accept; both same cycle as accept, visible next cycle.
REQ-031 Counters SHALL saturate at all-ones (no wrap).
REQ-032 cnt_clr SHALL zero both counters and take priority over a same-cycle increment.
REQ-033 redirect_pc SHALL hold its last value when redirect_valid=0 (no X).

Reset
REQ-034 reset SHALL take priority over all inputs, including flag_we, accept and cnt_clr.
REQ-035 On reset: state=IDLE, flags_q=3'b000, redirect_valid=0, redirect_pc=32'h0, br_cnt=0, taken_cnt=0; br_ready=1 the cycle after.
REQ-036 Reset asserted in HOLD SHALL drop the pending redirect; it is not replayed.

Verification
REQ-037 flag_we=1 with z=1,n=0,v=0; next cycle br_valid, br_cond=EQ, br_target=32'h0000_0040 -> next cycle redirect_valid=1, redirect_pc=32'h40, br_cnt=1, taken_cnt=1.
REQ-038 Same-cycle flag_we with z=0 and br_valid EQ while flags_q.Z=1 -> not taken (bypass), redirect_valid stays 0, br_cnt=1, taken_cnt=0.
REQ-039 flags n=1,v=1: LT not taken, GE taken; n=1,v=0: LT taken; VS/VC checked with v=1; ALWAYS/NEVER checked.
REQ-040 Taken branch, redirect_ready=0 for 3 cycles with br_valid high -> redirect_pc stable, br_ready=0, counters unchanged; redirect_ready=1 -> IDLE, second branch accepted next cycle.
REQ-041 Force br_cnt to 16'hFFFE, issue 3 ALWAYS branches -> br_cnt=16'hFFFF; cnt_clr with simultaneous accept -> both counters 0.
REQ-042 reset during HOLD with redirect_pc=32'h1234 -> next cycle redirect_valid=0, redirect_pc=0, flags_q=0, br_ready=1.
